goal_detect: RTL

Upstream stage of the score block. Watches the ball position once per frame and converts a ball entering the left or right goal zone into exactly one registered single-cycle `collision_flag1`/`collision_flag2` pulse per goal. After a goal it holds play for a fixed number of frames, then runs the round-restart handshake (`resetflagprime` out, `resetflag` back) with the score block. It re-arms only once the ball is back in the field, so one goal can never be counted twice.

---
 rtl/pong_pkg.sv | 39 +++
 rtl/goal_detect_if.sv | 50 +++++
 rtl/frame_hold_timer.sv | 41 ++++
 rtl/goal_detect.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong scoring path.
//   goal_state_t : goal_detect FSM states (ARM, PLAY, HOLD, SERVE, ACK)
//   H_RES        : horizontal field width in pixels
//   BALL_SIZE    : ball width in pixels (ball_x is the left edge)
//   GOAL_MARGIN  : depth of each goal zone in pixels
//   zone_decode  : returns {left, right} goal-zone hits for a ball position
// -----------------------------------------------------------------------------
package pong_pkg;

  typedef enum logic [2:0] {
    ARM   = 3'd0,
    PLAY  = 3'd1,
    HOLD  = 3'd2,
    SERVE = 3'd3,
    ACK   = 3'd4
  } goal_state_t;

  localparam int H_RES       = 640;
  localparam int BALL_SIZE   = 8;
  localparam int GOAL_MARGIN = 4;

  // x       : ball left edge
  // x_right : ball left edge + ball size, already formed without overflow
  // The comparison is signed so a margin wider than the field makes the right
  // zone always true rather than wrapping to a huge unsigned threshold.
  function automatic logic [1:0] zone_decode(input int x,
                                             input int x_right,
                                             input int h_res,
                                             input int margin);
    logic left;
    logic right;
    left  = (x < margin);
    right = (x_right > (h_res - margin));
    return {left, right};
  endfunction

endpackage

// File: rtl/goal_detect_if.sv
// -----------------------------------------------------------------------------
// goal_detect_if
// Bundle between the ball/frame source and score block on one side and
// goal_detect on the other.
//   ball_x          : ball left-edge x coordinate (X_W bits)
//   ball_valid      : one-cycle per-frame strobe, ball_x stable in that cycle
//   serve_btn       : synchronised serve request level
//   resetflag       : round-restart acknowledge from the score block
//   collision_flag1 : one-cycle pulse, player 1 scored (right goal)
//   collision_flag2 : one-cycle pulse, player 2 scored (left goal)
//   resetflagprime  : round-restart request level
//   busy            : high whenever goal_detect is not in PLAY
// Modports: master = environment side, slave = goal_detect.
// -----------------------------------------------------------------------------
interface goal_detect_if #(
  parameter int X_W = 10
) ();

  logic [X_W-1:0] ball_x;
  logic           ball_valid;
  logic           serve_btn;
  logic           resetflag;
  logic           collision_flag1;
  logic           collision_flag2;
  logic           resetflagprime;
  logic           busy;

  modport master (
    output ball_x,
    output ball_valid,
    output serve_btn,
    output resetflag,
    input  collision_flag1,
    input  collision_flag2,
    input  resetflagprime,
    input  busy
  );

  modport slave (
    input  ball_x,
    input  ball_valid,
    input  serve_btn,
    input  resetflag,
    output collision_flag1,
    output collision_flag2,
    output resetflagprime,
    output busy
  );

endinterface

// File: rtl/frame_hold_timer.sv
// -----------------------------------------------------------------------------
// frame_hold_timer
// Loadable frame down-counter used to freeze play after a goal.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset (count clears to 0)
//   load  : load HOLD_FRAMES (has priority over tick)
//   tick  : frame strobe; decrements a non-zero count
//   done  : high on the tick that takes the count from 1 to 0
// -----------------------------------------------------------------------------
module frame_hold_timer #(
  parameter int HOLD_FRAMES = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic done
);

  localparam int CW = $clog2(HOLD_FRAMES + 1);

  logic [CW-1:0] count;

  // NOTE: the async reset branch sits in the sensitivity list so the counter
  // clears without a clock; all state updates use <= so every register
  // samples pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(HOLD_FRAMES);
    end else if (tick && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  // Flagged on the emptying strobe itself so the FSM can leave HOLD on the
  // same edge the counter reaches zero.
  assign done = tick && (count == CW'(1));

endmodule

// File: rtl/goal_detect.sv
// -----------------------------------------------------------------------------
// goal_detect
// Watches the ball once per frame and turns entry into a goal zone into one
// registered single-cycle score pulse per goal. After a goal it freezes play
// for HOLD_FRAMES frames, waits for a serve, then runs the round-restart
// handshake (resetflagprime out, resetflag back). It re-arms only after the
// ball has been seen back in the field, so a lingering ball scores once.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : goal_detect_if.slave (ball_x, ball_valid, serve_btn, resetflag in;
//           collision_flag1/2, resetflagprime, busy out)
//
// Build option:
//   GOAL_AUTOSERVE_EN : when defined, SERVE exits the cycle after entry and
//                       serve_btn is ignored; otherwise a rising edge of
//                       serve_btn is required.
// -----------------------------------------------------------------------------
module goal_detect #(
  parameter int H_RES       = pong_pkg::H_RES,
  parameter int BALL_SIZE   = pong_pkg::BALL_SIZE,
  parameter int GOAL_MARGIN = pong_pkg::GOAL_MARGIN,
  parameter int HOLD_FRAMES = 60,
  parameter int X_W         = 10
) (
  input  logic         clk,
  input  logic         reset,
  goal_detect_if.slave bus
);

  import pong_pkg::*;

  goal_state_t state;
  logic        flag1_q;
  logic        flag2_q;
  logic        req_q;
  logic        busy_q;

  // Zone compare. The right edge is formed one bit wider than ball_x so a
  // ball near the top of the coordinate range cannot wrap into the field.
  logic [X_W:0] right_edge;
  logic [1:0]   zones;
  logic         in_left;
  logic         in_right;
  logic         in_field;

  assign right_edge = {1'b0, bus.ball_x} + (X_W + 1)'(BALL_SIZE);
  assign zones      = zone_decode(int'(bus.ball_x), int'(right_edge),
                                  H_RES, GOAL_MARGIN);
  assign in_left    = zones[1];
  assign in_right   = zones[0];
  assign in_field   = !in_left && !in_right;

  // Hold timer: loaded on the scoring frame, counts every later frame strobe.
  logic hold_load;
  logic hold_done;

  assign hold_load = (state == PLAY) && bus.ball_valid && (in_left || in_right);

  frame_hold_timer #(
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (hold_load),
    .tick  (bus.ball_valid),
    .done  (hold_done)
  );

  // Serve trigger.
  logic serve_go;

`ifdef GOAL_AUTOSERVE_EN
  assign serve_go = 1'b1;
`else
  // Previous-value register tracks the button in every state, so a button
  // already held when SERVE is entered shows no edge.
  logic serve_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      serve_prev <= 1'b0;
    end else begin
      serve_prev <= bus.serve_btn;
    end
  end

  assign serve_go = bus.serve_btn && !serve_prev;
`endif

  // Round FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ARM;
      flag1_q <= 1'b0;
      flag2_q <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      // Score flags are pulses: cleared every cycle unless a goal sets them.
      flag1_q <= 1'b0;
      flag2_q <= 1'b0;

      case (state)
        ARM: begin
          if (bus.ball_valid && in_field) begin
            state  <= PLAY;
            busy_q <= 1'b0;
          end
        end

        PLAY: begin
          if (bus.ball_valid && (in_left || in_right)) begin
            // Right goal wins if degenerate parameters overlap the zones.
            flag1_q <= in_right;
            flag2_q <= in_left && !in_right;
            state   <= HOLD;
            busy_q  <= 1'b1;
          end
        end

        HOLD: begin
          if (hold_done) begin
            state <= SERVE;
          end
        end

        SERVE: begin
          if (serve_go) begin
            req_q <= 1'b1;
            state <= ACK;
          end
        end

        ACK: begin
          if (bus.resetflag) begin
            req_q <= 1'b0;
            state <= ARM;
          end
        end

        default: begin
          state  <= ARM;
          req_q  <= 1'b0;
          busy_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.collision_flag1 = flag1_q;
  assign bus.collision_flag2 = flag2_q;
  assign bus.resetflagprime  = req_q;
  assign bus.busy            = busy_q;

endmodule
